ahb_mem_slave: RTL and testbench

AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_mem_sram_array.sv | 26 ++
 rtl/ahb_mem_slave.sv | 151 +++++++++++++++
 tb/tb_ahb_mem_slave.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and slave FSM states for the memory slave slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

  // Little-endian byte-lane enables for an aligned transfer.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << a;
      HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mem_sram_array.sv
// Word-wide storage with per-byte write enables, synchronous write, combinational read.
module ahb_mem_sram_array #(
  parameter int MEM_WORDS = 256,
  localparam int IDX_W = $clog2(MEM_WORDS)
) (
  input  logic             HCLK,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: programmable wait states, two-cycle ERROR response,
// pipelined back-to-back transfers, byte/half/word access.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int         IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] WS4   = 4'(WAIT_STATES);

  ahb_state_e  state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_p1;
  logic        write_p1;
  logic [2:0]  size_p1;
  logic        vld_p1;
  logic        hreadyout_q;
  logic        hresp_q;

  logic             accept;
  logic             acc_err;
  logic             complete;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_rdata;
  logic             unused_ok;

  function automatic logic xfer_error(input logic [31:0] a, input logic [2:0] s);
    logic [32:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    xfer_error = (s > HSIZE_WORD) ||
                 ((s == HSIZE_HALF) && a[0]) ||
                 ((s == HSIZE_WORD) && (a[1:0] != 2'b00)) ||
                 diff[32] ||
                 ((diff[31:0] >> 2) >= 32'(MEM_WORDS));
  endfunction

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

  // Address phase: only sampled while this slave is presenting ready.
  assign accept  = HSEL && HREADY && hreadyout_q &&
                   ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign acc_err = accept && xfer_error(HADDR, HSIZE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      addr_p1     <= 32'd0;
      write_p1    <= 1'b0;
      size_p1     <= 3'd0;
      vld_p1      <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept) begin
            addr_p1  <= HADDR;
            write_p1 <= HWRITE;
            size_p1  <= HSIZE;
            if (acc_err) begin
              state       <= ST_ERR1;
              vld_p1      <= 1'b0;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (WS4 != 4'd0) begin
              state       <= ST_WAIT;
              wait_cnt    <= WS4;
              vld_p1      <= 1'b1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_OKAY;
            end else begin
              state       <= ST_IDLE;
              vld_p1      <= 1'b1;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
            end
          end else begin
            state       <= ST_IDLE;
            vld_p1      <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state       <= ST_IDLE;
          vld_p1      <= 1'b0;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Data phase: an OKAY transfer completes on the cycle ready is high again.
  assign complete = vld_p1 && hreadyout_q;
  assign mem_we   = complete && write_p1;
  assign mem_be   = lane_mask(size_p1, addr_p1[1:0]);
  assign mem_idx  = IDX_W'((addr_p1 - BASE_ADDR) >> 2);

  ahb_mem_sram_array #(
    .MEM_WORDS(MEM_WORDS)
  ) u_sram (
    .HCLK (HCLK),
    .we   (mem_we),
    .be   (mem_be),
    .addr (mem_idx),
    .wdata(HWDATA),
    .rdata(mem_rdata)
  );

  assign HRDATA    = (complete && !write_p1) ? mem_rdata : 32'd0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: one instance with one wait state, one with none, sharing a
// pipelined bus driver and checked against a per-instance word-array model.
module tb_ahb_mem_slave;
  import ahb_pkg::*;

  localparam int MW   = 64;
  localparam int NMAX = 80;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        hsel = 1'b0, dsel = 1'b0, hwrite = 1'b0, hmastlock = 1'b0;
  logic [31:0] haddr = 32'd0, hwdata = 32'd0;
  logic [2:0]  hsize = 3'd0, hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [31:0] rd_a, rd_b, rd;
  logic        ro_a, ro_b, rs_a, rs_b, ro, rs;

  always #5 HCLK = ~HCLK;

  ahb_mem_slave #(.MEM_WORDS(MW), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & ~dsel), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock), .HTRANS(htrans),
    .HREADY(ro_a), .HWDATA(hwdata), .HRDATA(rd_a), .HREADYOUT(ro_a), .HRESP(rs_a));

  ahb_mem_slave #(.MEM_WORDS(MW), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & dsel), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock), .HTRANS(htrans),
    .HREADY(ro_b), .HWDATA(hwdata), .HRDATA(rd_b), .HREADYOUT(ro_b), .HRESP(rs_b));

  assign ro = dsel ? ro_b : ro_a;
  assign rs = dsel ? rs_b : rs_a;
  assign rd = dsel ? rd_b : rd_a;

  int errors = 0;
  int checks = 0;

  // Transfer list for one driver run, and what was observed per data phase.
  int          n;
  logic        t_sel   [NMAX];
  logic [1:0]  t_trans [NMAX];
  logic        t_write [NMAX];
  logic [2:0]  t_size  [NMAX];
  logic [31:0] t_addr  [NMAX];
  logic [31:0] t_wdata [NMAX];
  logic [31:0] r_low   [NMAX];
  logic        r_first [NMAX];
  logic        r_resp  [NMAX];
  logic [31:0] r_rdata [NMAX];

  logic [31:0] mdl [2][MW];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    t_sel[n] = sel; t_trans[n] = tr; t_write[n] = wr;
    t_size[n] = sz; t_addr[n] = a; t_wdata[n] = wd;
    n++;
  endtask

  task automatic drive_addr(input int i);
    hsel = t_sel[i]; htrans = t_trans[i]; hwrite = t_write[i];
    hsize = t_size[i]; haddr = t_addr[i];
    hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = 3'd0; haddr = 32'd0;
  endtask

  task automatic run();
    int low;
    @(posedge HCLK); #1;
    drive_addr(0);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK); #1;
      if (i + 1 < n) drive_addr(i + 1);
      else drive_idle();
      hwdata = t_wdata[i];
      low = 0;
      r_first[i] = 1'b0;
      @(negedge HCLK);
      while (!ro && low < 20) begin
        if (low == 0) r_first[i] = rs;
        low++;
        @(negedge HCLK);
      end
      r_low[i] = 32'(low); r_resp[i] = rs; r_rdata[i] = rd;
    end
    @(posedge HCLK); #1;
    drive_idle();
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
    if (s > 2) return 1'b1;
    if (s == 1 && (a % 2) != 0) return 1'b1;
    if (s == 2 && (a % 4) != 0) return 1'b1;
    if (a / 4 >= MW) return 1'b1;
    return 1'b0;
  endfunction

  // Walk the run in bus order: each transfer sees every earlier write.
  task automatic check_run(input string name);
    int  d, ws, exp_low, w;
    bit  xfer, err, hit;
    logic [31:0] exp_rd;
    d  = dsel ? 1 : 0;
    ws = dsel ? 0 : 1;
    for (int i = 0; i < n; i++) begin
      xfer = t_sel[i] && (t_trans[i] == HTRANS_NONSEQ || t_trans[i] == HTRANS_SEQ);
      err  = xfer && model_err(t_addr[i], t_size[i]);
      exp_low = !xfer ? 0 : (err ? 1 : ws);
      w = int'(t_addr[i] / 4);
      exp_rd = (xfer && !err && !t_write[i]) ? mdl[d][w] : 32'd0;
      chk($sformatf("%s[%0d].low", name, i), r_low[i], 32'(exp_low));
      chk($sformatf("%s[%0d].resp", name, i), 32'(r_resp[i]), 32'(err));
      if (exp_low > 0) chk($sformatf("%s[%0d].first_resp", name, i), 32'(r_first[i]), 32'(err));
      chk($sformatf("%s[%0d].rdata", name, i), r_rdata[i], exp_rd);
      if (xfer && !err && t_write[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (t_size[i] == 0) hit = (b == int'(t_addr[i] % 4));
          else if (t_size[i] == 1) hit = ((b / 2) == int'((t_addr[i] / 2) % 2));
          else hit = 1'b1;
          if (hit) mdl[d][w][8*b +: 8] = t_wdata[i][8*b +: 8];
        end
      end
    end
  endtask

  task automatic add_random();
    int k;
    logic [2:0] sz;
    logic [31:0] a;
    k = int'($urandom_range(0, 9));
    if (k == 0) begin
      case ($urandom_range(0, 2))
        0: add(1'b1, HTRANS_IDLE, 1'($urandom), 3'd2, 32'($urandom_range(0, 15)) * 4, $urandom);
        1: add(1'b1, HTRANS_BUSY, 1'b1, 3'd2, 32'($urandom_range(0, 15)) * 4, $urandom);
        default: add(1'b0, HTRANS_NONSEQ, 1'b1, 3'd2, 32'($urandom_range(0, 15)) * 4, $urandom);
      endcase
    end else if (k == 1) begin
      case ($urandom_range(0, 2))
        0: add(1'b1, HTRANS_NONSEQ, 1'($urandom), 3'($urandom_range(3, 7)), 32'd8, $urandom);
        1: add(1'b1, HTRANS_SEQ, 1'b1, 3'd1, 32'($urandom_range(0, 15)) * 4 + 32'd1, $urandom);
        default: add(1'b1, HTRANS_NONSEQ, 1'($urandom), 3'd2,
                     32'(MW * 4) + 32'($urandom_range(0, 15)) * 4, $urandom);
      endcase
    end else begin
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 15)) * 4;
      if (sz == 0) a = a + 32'($urandom_range(0, 3));
      if (sz == 1) a = a + 32'($urandom_range(0, 1)) * 2;
      add(1'b1, $urandom_range(0, 1) == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 1'($urandom), sz, a, $urandom);
    end
  endtask

  logic [31:0] prior;

  initial begin
    // Asynchronous reset state, before any clock edge
    #1 HRESETn = 1'b0;
    #2;
    chk("reset.a.hreadyout", 32'(ro_a), 32'd1);
    chk("reset.a.hresp", 32'(rs_a), 32'd0);
    chk("reset.a.hrdata", rd_a, 32'd0);
    chk("reset.b.hreadyout", 32'(ro_b), 32'd1);
    chk("reset.b.hresp", 32'(rs_b), 32'd0);
    chk("reset.b.hrdata", rd_b, 32'd0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;

    // Give both memories known contents
    for (int d = 0; d < 2; d++) begin
      dsel = (d == 1);
      n = 0;
      for (int w = 0; w < MW; w++) add(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(w * 4), $urandom);
      run(); check_run($sformatf("init%0d", d));
    end

    // One wait state: word write then read
    dsel = 1'b0;
    n = 0;
    add(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    run(); check_run("ws1_wr");
    n = 0;
    add(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    run(); check_run("ws1_rd");
    chk("ws1_rd.value", r_rdata[0], 32'hDEADBEEF);
    chk("ws1_rd.wait", r_low[0], 32'd1);

    // Zero wait: byte write then back-to-back word read
    dsel = 1'b1;
    n = 0;
    add(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    add(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h11, 32'h0000AA00);
    add(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    run(); check_run("ws0_b2b");
    chk("ws0_b2b.value", r_rdata[2], 32'hDEADAAEF);
    chk("ws0_b2b.wait", r_low[2], 32'd0);

    // Misaligned half write errors and leaves the word alone
    dsel = 1'b0;
    n = 0;
    add(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h01020304);
    add(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h21, 32'hFFFFFFFF);
    add(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
    run(); check_run("half_err");
    chk("half_err.err1", 32'(r_first[1]), 32'd1);
    chk("half_err.err2", 32'(r_resp[1]), 32'd1);
    chk("half_err.old", r_rdata[2], 32'h01020304);

    // Out-of-range and oversized errors, each followed by a transfer taken in ERR2
    for (int d = 0; d < 2; d++) begin
      dsel = (d == 1);
      n = 0;
      add(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'(MW * 4), 32'h0);
      add(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'hCAFEF00D);
      add(1'b1, HTRANS_NONSEQ, 1'b1, 3'd3, 32'h44, 32'h11111111);
      add(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
      run(); check_run($sformatf("range_err%0d", d));
      chk($sformatf("range_err%0d.resp", d), 32'(r_resp[0]), 32'd1);
      chk($sformatf("range_err%0d.after", d), r_rdata[3], 32'hCAFEF00D);
    end

    // BUSY, IDLE and unselected cycles are zero-wait OKAY with no write
    dsel = 1'b0;
    n = 0;
    add(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h40, 32'h99999999);
    add(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'h88888888);
    add(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h40, 32'h77777777);
    add(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
    run(); check_run("noxfer");
    chk("noxfer.unchanged", r_rdata[3], 32'hCAFEF00D);

    // Reset during the wait state of a write aborts it
    n = 0;
    add(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'hA5A50F0F);
    run(); check_run("rst_pre");
    prior = mdl[0][12];
    @(posedge HCLK); #1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h30; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge HCLK); #1;
    drive_idle();
    hwdata = 32'h12345678;
    @(negedge HCLK);
    chk("rst.in_wait", 32'(ro_a), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst.hreadyout", 32'(ro_a), 32'd1);
    chk("rst.hresp", 32'(rs_a), 32'd0);
    chk("rst.hrdata", rd_a, 32'd0);
    @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    n = 0;
    add(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30, 32'h0);
    run(); check_run("rst_post");
    chk("rst_post.prior", r_rdata[0], 32'hA5A50F0F);
    chk("rst_post.model", r_rdata[0], prior);

    // Randomized traffic on both instances
    for (int rep = 0; rep < 4; rep++) begin
      dsel = (rep % 2 == 1);
      n = 0;
      for (int k = 0; k < 40; k++) add_random();
      run(); check_run($sformatf("rand%0d", rep));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
